// File: rtl/io_scan_ctrl.sv
// io_scan_ctrl: board pin-walk sequencer.
// Drives one pin at a time across N_PINS tri-stateable pads and releases
// all other pins. Each pin is driven for a programmable dwell time. One
// break-before-make gap cycle follows each pin, with all enables low. A scan
// runs a programmable number of full passes (0 = run until stop).
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           begin scan (sampled only when idle)
//   stop            abort scan (honoured in any state; wins over start)
//   dwell           cycles each pin is driven (0 treated as 1), latched on start
//   polarity        0 = walk-zero, 1 = walk-one, latched on start
//   loops           full passes to run (0 = endless), latched on start
//   pause           (only with SCAN_PAUSE_EN) freezes the scan while driving
//   out_val/out_oe  registered pad values / one-hot-or-zero pad enables
//   pin_idx         index of the current pin
//   busy            high while driving or in a gap cycle
//   done            one-cycle pulse when a counted scan completes normally
//
// Build option: define SCAN_PAUSE_EN to add the pause input.
module io_scan_ctrl #(
  parameter int N_PINS  = 21,
  parameter int DWELL_W = 21,
  parameter int LOOP_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               polarity,
  input  logic [LOOP_W-1:0]  loops,
`ifdef SCAN_PAUSE_EN
  input  logic               pause,
`endif
  output logic [N_PINS-1:0]  out_val,
  output logic [N_PINS-1:0]  out_oe,
  output logic [4:0]         pin_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP,
    S_FINISH
  } state_t;

  localparam logic [4:0] LAST_PIN = 5'(N_PINS - 1);

  state_t             state_q, state_d;
  logic [4:0]         pin_idx_q, pin_idx_d;
  logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               pol_q, pol_d;
  logic [LOOP_W-1:0]  loops_q, loops_d;
  logic [LOOP_W-1:0]  loop_cnt_q, loop_cnt_d;
  logic [N_PINS-1:0]  out_val_q, out_val_d;
  logic [N_PINS-1:0]  out_oe_q, out_oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               freeze;
  logic [DWELL_W-1:0] dwell_eff;
  logic [4:0]         pin_next;
  logic [N_PINS-1:0]  sel_next;
  logic [N_PINS-1:0]  sel_first;

  always_comb begin
`ifdef SCAN_PAUSE_EN
    freeze = pause;
`else
    freeze = 1'b0;
`endif
  end

  always_comb begin
    dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    pin_next  = pin_idx_q + 5'd1;
    sel_next  = N_PINS'(1) << pin_next;
    sel_first = N_PINS'(1);
  end

  always_comb begin
    state_d     = state_q;
    pin_idx_d   = pin_idx_q;
    dwell_lat_d = dwell_lat_q;
    dwell_cnt_d = dwell_cnt_q;
    pol_d       = pol_q;
    loops_d     = loops_q;
    loop_cnt_d  = loop_cnt_q;
    out_val_d   = out_val_q;
    out_oe_d    = out_oe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          dwell_lat_d = dwell_eff;
          pol_d       = polarity;
          loops_d     = loops;
          pin_idx_d   = '0;
          loop_cnt_d  = '0;
          dwell_cnt_d = dwell_eff - DWELL_W'(1);
          state_d     = S_DRIVE;
          busy_d      = 1'b1;
          out_oe_d    = sel_first;
          out_val_d   = polarity ? sel_first : '0;
        end
      end

      S_DRIVE: begin
        if (!freeze) begin
          if (dwell_cnt_q == '0) begin
            state_d  = S_GAP;
            out_oe_d = '0;
          end else begin
            dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          end
        end
      end

      S_GAP: begin
        dwell_cnt_d = dwell_lat_q - DWELL_W'(1);
        if (pin_idx_q != LAST_PIN) begin
          pin_idx_d = pin_next;
          state_d   = S_DRIVE;
          out_oe_d  = sel_next;
          out_val_d = pol_q ? sel_next : '0;
        end else begin
          pin_idx_d = '0;
          // Saturate so an endless scan never wraps the pass counter.
          if (loop_cnt_q != '1) begin
            loop_cnt_d = loop_cnt_q + LOOP_W'(1);
          end
          if ((loops_q != '0) && ((loop_cnt_q + LOOP_W'(1)) == loops_q)) begin
            state_d   = S_FINISH;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            out_oe_d  = '0;
            out_val_d = '0;
          end else begin
            state_d   = S_DRIVE;
            out_oe_d  = sel_first;
            out_val_d = pol_q ? sel_first : '0;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including pause and a pending finish.
    if (stop && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      out_oe_d  = '0;
      out_val_d = '0;
      busy_d    = 1'b0;
      pin_idx_d = '0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pin_idx_q   <= '0;
      dwell_lat_q <= '0;
      dwell_cnt_q <= '0;
      pol_q       <= 1'b0;
      loops_q     <= '0;
      loop_cnt_q  <= '0;
      out_val_q   <= '0;
      out_oe_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pin_idx_q   <= pin_idx_d;
      dwell_lat_q <= dwell_lat_d;
      dwell_cnt_q <= dwell_cnt_d;
      pol_q       <= pol_d;
      loops_q     <= loops_d;
      loop_cnt_q  <= loop_cnt_d;
      out_val_q   <= out_val_d;
      out_oe_q    <= out_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_val = out_val_q;
  assign out_oe  = out_oe_q;
  assign pin_idx = pin_idx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_io_scan_ctrl.sv
// Testbench for io_scan_ctrl: scan scenarios from a vector table are checked
// cycle by cycle against a time-based reference model through a scoreboard
// queue. Hand-written sequences cover start/stop collision, asynchronous
// reset mid-scan and (with SCAN_PAUSE_EN) pause.
module tb_io_scan_ctrl;
  localparam int N       = 21;
  localparam int DWELL_W = 21;
  localparam int LOOP_W  = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [DWELL_W-1:0] dwell = '0;
  logic               polarity = 1'b0;
  logic [LOOP_W-1:0]  loops = '0;
  logic               pause = 1'b0;
  logic [N-1:0]       out_val;
  logic [N-1:0]       out_oe;
  logic [4:0]         pin_idx;
  logic               busy;
  logic               done;

  io_scan_ctrl #(.N_PINS(N), .DWELL_W(DWELL_W), .LOOP_W(LOOP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dwell(dwell),
    .polarity(polarity), .loops(loops),
`ifdef SCAN_PAUSE_EN
    .pause(pause),
`endif
    .out_val(out_val), .out_oe(out_oe), .pin_idx(pin_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] oe;
    logic [N-1:0] val;
    logic [4:0]   pin;
    logic         busy;
    logic         done;
    logic         chk_val;
  } exp_t;

  typedef struct {
    int dwell;
    bit pol;
    int loops;
    int ncyc;
    bit do_stop;
    int poke_at;
  } vec_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t mk(logic [N-1:0] oe, logic [N-1:0] val, int pin,
                              logic b, logic d, logic cv);
    exp_t e;
    e.oe = oe; e.val = val; e.pin = 5'(pin); e.busy = b; e.done = d; e.chk_val = cv;
    return e;
  endfunction

  // Reference: cycle u counts from the first cycle after the start edge.
  function automatic exp_t model(int d_in, bit pol, int lp, int u);
    int d, p, total, pin, phase;
    logic [N-1:0] oh;
    d = (d_in == 0) ? 1 : d_in;
    p = d + 1;
    total = lp * N * p;
    if (lp != 0 && u == total) return mk('0, '0, 0, 1'b0, 1'b1, 1'b0);
    if (lp != 0 && u > total)  return mk('0, '0, 0, 1'b0, 1'b0, 1'b0);
    pin = (u / p) % N;
    phase = u % p;
    oh = '0;
    oh[pin] = 1'b1;
    return mk((phase < d) ? oh : '0, pol ? oh : '0, pin, 1'b1, 1'b0, 1'b1);
  endfunction

  task automatic cmp(string nm, int u, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, u, act, expv);
    end
  endtask

  task automatic check_now(int u);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty cycle=%0d actual=0 expected=1", u);
      return;
    end
    e = q.pop_front();
    cmp("out_oe", u, 32'(out_oe), 32'(e.oe));
    cmp("pin_idx", u, 32'(pin_idx), 32'(e.pin));
    cmp("busy", u, 32'(busy), 32'(e.busy));
    cmp("done", u, 32'(done), 32'(e.done));
    cmp("oe_onehot", u, 32'($countones(out_oe) <= 1), 32'd1);
    if (e.chk_val) cmp("out_val", u, 32'(out_val), 32'(e.val));
  endtask

  task automatic pop_check(int u);
    @(posedge clk);
    #1;
    check_now(u);
  endtask

  task automatic run_vec(vec_t v);
    @(negedge clk);
    dwell = DWELL_W'(v.dwell);
    polarity = v.pol;
    loops = LOOP_W'(v.loops);
    start = 1'b1;
    q.push_back(model(v.dwell, v.pol, v.loops, 0));
    for (int u = 0; u < v.ncyc; u++) begin
      pop_check(u);
      @(negedge clk);
      start = 1'b0;
      // Inputs wander while busy; only the latched config may matter.
      dwell = DWELL_W'($urandom);
      polarity = 1'($urandom);
      loops = LOOP_W'($urandom);
      if (u == v.poke_at) start = 1'b1;
      if (u + 1 < v.ncyc) q.push_back(model(v.dwell, v.pol, v.loops, u + 1));
    end
    if (v.do_stop) begin
      stop = 1'b1;
      q.push_back(mk('0, '0, 0, 1'b0, 1'b0, 1'b1));
      pop_check(-1);
      @(negedge clk);
      stop = 1'b0;
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{dwell: 3, pol: 1'b0, loops: 1, ncyc: 84 + 3,  do_stop: 1'b0, poke_at: 10};
    vecs[1] = '{dwell: 0, pol: 1'b1, loops: 2, ncyc: 84 + 3,  do_stop: 1'b0, poke_at: -1};
    vecs[2] = '{dwell: 2, pol: 1'b1, loops: 0, ncyc: 200,     do_stop: 1'b1, poke_at: 50};
    vecs[3] = '{dwell: 5, pol: 1'b1, loops: 3, ncyc: 378 + 3, do_stop: 1'b0, poke_at: 200};
    vecs[4] = '{dwell: 1, pol: 1'b0, loops: 0, ncyc: 50,      do_stop: 1'b1, poke_at: -1};

    // Reset state
    #1;
    q.push_back(mk('0, '0, 0, 1'b0, 1'b0, 1'b1));
    check_now(-1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // start and stop together while idle: stop wins
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    dwell = DWELL_W'(2);
    q.push_back(mk('0, '0, 0, 1'b0, 1'b0, 1'b0));
    pop_check(-2);
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    q.push_back(mk('0, '0, 0, 1'b0, 1'b0, 1'b0));
    pop_check(-3);

    // Asynchronous reset while driving pin 7
    run_vec('{dwell: 3, pol: 1'b1, loops: 0, ncyc: 30, do_stop: 1'b0, poke_at: -1});
    rst = 1'b1;
    #1;
    q.push_back(mk('0, '0, 0, 1'b0, 1'b0, 1'b1));
    check_now(-4);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      q.push_back(mk('0, '0, 0, 1'b0, 1'b0, 1'b1));
      pop_check(-5);
      @(negedge clk);
    end
    run_vec('{dwell: 1, pol: 1'b1, loops: 1, ncyc: 42 + 3, do_stop: 1'b0, poke_at: -1});

`ifdef SCAN_PAUSE_EN
    // Pause 5 cycles mid-dwell on pin 0 (dwell 4): pin 0 is driven 9 cycles
    @(negedge clk);
    dwell = DWELL_W'(4);
    polarity = 1'b1;
    loops = '0;
    start = 1'b1;
    for (int u = 0; u <= 10; u++) begin
      q.push_back(mk((u <= 8) ? N'(1) : ((u == 9) ? N'(0) : N'(2)),
                     (u <= 9) ? N'(1) : N'(2), (u <= 9) ? 0 : 1,
                     1'b1, 1'b0, 1'b1));
      pop_check(100 + u);
      @(negedge clk);
      start = 1'b0;
      pause = (u >= 1 && u <= 5);
    end
    pause = 1'b1;
    q.push_back(mk(N'(2), N'(2), 1, 1'b1, 1'b0, 1'b1));
    pop_check(111);
    @(negedge clk);
    stop = 1'b1;
    q.push_back(mk('0, '0, 0, 1'b0, 1'b0, 1'b1));
    pop_check(112);
    @(negedge clk);
    stop = 1'b0;
    pause = 1'b0;
`endif

    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
